// File: rtl/hidden_layer_mac.sv
// Hidden-layer multiply-accumulate engine: streams 66 weight/activation pairs per
// node into a 48-bit Q16.16 accumulator and emits one saturated result per node.
module hidden_layer_mac #(
  parameter int ih_mem_height      = 64,
  parameter int element_width      = 32,
  parameter int no_of_hidden_nodes = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [4:0]               column_number,
  output logic [6:0]               elem_index,
  input  logic                     w_valid,
  input  logic [element_width-1:0] w_data,
  input  logic [element_width-1:0] x_data,
  output logic                     w_ready,
  output logic                     node_valid,
  output logic [element_width-1:0] node_data,
  input  logic                     node_ready,
  output logic                     layer_done,
  output logic [1:0]               dbg_state
);

  localparam int EW     = element_width;
  localparam int ACC_W  = 48;
  localparam int FRAC   = 16;
  localparam int PROD_W = 2 * EW;

  localparam logic [6:0] LAST_ELEM = 7'(ih_mem_height + 1);
  localparam logic [4:0] LAST_COL  = 5'(no_of_hidden_nodes - 1);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-EW+1){1'b1}}, {(EW-1){1'b0}}};

  // Handshakes: a pair moves on w_valid && w_ready, a result on node_valid && node_ready;
  // valid-side data must hold until the handshake, ready may change freely.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [4:0]               col_q, col_d;
  logic [6:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [EW-1:0]            data_q, data_d;
  logic                     done_q, done_d;

  logic signed [PROD_W-1:0] w_ext, x_ext, prod_full;
  logic signed [ACC_W-1:0]  prod_sh, acc_sum;
  logic [EW-1:0]            sat_val;
  logic                     unused_frac;

  // Full-width signed product, then arithmetic shift by FRAC is a bit slice.
  assign w_ext       = {{EW{w_data[EW-1]}}, w_data};
  assign x_ext       = {{EW{x_data[EW-1]}}, x_data};
  assign prod_full   = w_ext * x_ext;
  assign prod_sh     = prod_full[ACC_W+FRAC-1:FRAC];
  assign unused_frac = ^prod_full[FRAC-1:0];
  assign acc_sum     = acc_q + prod_sh;

  always_comb begin
    sat_val = acc_sum[EW-1:0];
    if (acc_sum > SAT_MAX) begin
      sat_val = {1'b0, {(EW-1){1'b1}}};
    end else if (acc_sum < SAT_MIN) begin
      sat_val = {1'b1, {(EW-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    data_d  = data_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          col_d   = '0;
          idx_d   = '0;
          acc_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (w_valid) begin
          acc_d = acc_sum;
          // Index parks at the last element; it is cleared on the result handshake.
          if (idx_q == LAST_ELEM) begin
            data_d  = sat_val;
            state_d = OUTPUT;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      OUTPUT: begin
        if (node_ready) begin
          if (col_q == LAST_COL) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            col_d   = col_q + 5'd1;
            idx_d   = '0;
            acc_d   = '0;
            state_d = ACCUM;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign column_number = col_q;
  assign elem_index    = idx_q;
  assign w_ready       = (state_q == ACCUM);
  assign node_valid    = (state_q == OUTPUT);
  assign node_data     = data_q;
  assign layer_done    = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac: Q16.16 dot-product model feeding an
// expected-result queue, checked with immediate assertions at each point.
module tb_hidden_layer_mac;

  localparam int EW    = 32;
  localparam int ELEMS = 66;
  localparam int NODES = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          w_valid = 1'b0;
  logic          node_ready = 1'b0;
  logic [EW-1:0] w_data = '0;
  logic [EW-1:0] x_data = '0;
  logic [4:0]    column_number;
  logic [6:0]    elem_index;
  logic          w_ready;
  logic          node_valid;
  logic [EW-1:0] node_data;
  logic          layer_done;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  hidden_layer_mac dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .column_number (column_number),
    .elem_index    (elem_index),
    .w_valid       (w_valid),
    .w_data        (w_data),
    .x_data        (x_data),
    .w_ready       (w_ready),
    .node_valid    (node_valid),
    .node_data     (node_data),
    .node_ready    (node_ready),
    .layer_done    (layer_done),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic signed [47:0] model_beat(input logic signed [47:0] acc,
                                                     input logic [31:0] w, input logic [31:0] x);
    logic signed [63:0] p;
    p = $signed(w) * $signed(x);
    p = p >>> 16;
    return acc + p[47:0];
  endfunction

  function automatic logic [31:0] model_sat(input logic signed [47:0] a);
    if (a > 48'sh0000_7FFF_FFFF) return 32'h7FFF_FFFF;
    if (a < 48'shFFFF_8000_0000) return 32'h8000_0000;
    return a[31:0];
  endfunction

  task automatic gen(input int pat, output logic [31:0] w, output logic [31:0] x);
    case (pat)
      0: begin w = 32'h0001_0000; x = 32'h0002_0000; end
      1: begin w = 32'h7FFF_0000; x = 32'h7FFF_0000; end
      2: begin w = 32'h8000_0000; x = 32'h7FFF_0000; end
      3: begin
        w = $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000;
        x = $urandom_range(0, 32'h0003_FFFF) - 32'h0002_0000;
      end
      default: begin w = $urandom(); x = $urandom(); end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_col"},   32'(column_number), 32'd0);
    check({tag, "_elem"},  32'(elem_index), 32'd0);
    check({tag, "_data"},  node_data, 32'd0);
    check({tag, "_valid"}, 32'(node_valid), 32'd0);
    check({tag, "_wrdy"},  32'(w_ready), 32'd0);
    check({tag, "_done"},  32'(layer_done), 32'd0);
  endtask

  // Called at a negedge in ACCUM; returns at the negedge after the 66th beat.
  task automatic feed_node(input int pat, input bit gaps);
    logic signed [47:0] acc;
    logic [31:0] w, x;
    int beats;
    int cyc;
    bit tog;
    acc = '0; beats = 0; cyc = 0; tog = 1'b1;
    while (beats < ELEMS && cyc < 1000) begin
      if (gaps) check("gap_elem_index", 32'(elem_index), 32'(beats));
      gen(pat, w, x);
      w_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      w_data = w;
      x_data = x;
      if (w_valid && w_ready) begin
        acc = model_beat(acc, w, x);
        beats++;
      end
      cyc++;
      @(negedge clk);
    end
    w_valid = 1'b0;
    if (cyc >= 1000) check("feed_timeout", 32'(beats), 32'(ELEMS));
    exp_q.push_back(model_sat(acc));
  endtask

  task automatic collect(input int hold);
    logic [31:0] d0, e;
    logic [4:0]  c0;
    check("node_valid_latency", 32'(node_valid), 32'd1);
    if (hold > 0) begin
      d0 = node_data;
      c0 = column_number;
      for (int k = 0; k < hold; k++) begin
        check("hold_valid", 32'(node_valid), 32'd1);
        check("hold_wready", 32'(w_ready), 32'd0);
        check("hold_data", node_data, d0);
        check("hold_col", 32'(column_number), 32'(c0));
        @(negedge clk);
      end
      node_ready = 1'b1;
    end
    check("exp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("node_data", node_data, e);
    @(negedge clk);
  endtask

  initial begin
    int pat;
    bit gaps;
    int hold;
    logic [31:0] w, x;

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start_wready", 32'(w_ready), 32'd0);

    // Full pass of NODES columns
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_wready", 32'(w_ready), 32'd1);
    check("start_elem", 32'(elem_index), 32'd0);
    for (int n = 0; n < NODES; n++) begin
      check("col_step", 32'(column_number), 32'(n));
      if (n == 6) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ignored_col", 32'(column_number), 32'd6);
        check("start_ignored_elem", 32'(elem_index), 32'd0);
        check("start_ignored_state", 32'(dbg_state), 32'd1);
      end
      case (n)
        0: begin pat = 0; gaps = 1'b0; hold = 0; end
        1: begin pat = 1; gaps = 1'b0; hold = 0; end
        2: begin pat = 2; gaps = 1'b0; hold = 0; end
        3: begin pat = 3; gaps = 1'b1; hold = 0; end
        4: begin pat = 3; gaps = 1'b0; hold = 5; end
        5: begin pat = 4; gaps = 1'b0; hold = 0; end
        default: begin pat = 3; gaps = n[0]; hold = 0; end
      endcase
      node_ready = (hold == 0);
      feed_node(pat, gaps);
      if (n == 0) check("unity_result", node_data, 32'h0084_0000);
      if (n == 1) check("sat_pos", node_data, 32'h7FFF_FFFF);
      if (n == 2) check("sat_neg", node_data, 32'h8000_0000);
      collect(hold);
      if (n < NODES - 1) begin
        check("next_node_wready", 32'(w_ready), 32'd1);
        check("next_node_elem", 32'(elem_index), 32'd0);
      end else begin
        check("layer_done_pulse", 32'(layer_done), 32'd1);
        check("done_idle_wready", 32'(w_ready), 32'd0);
        check("no_col_wrap", 32'(column_number), 32'(NODES - 1));
        @(negedge clk);
        check("layer_done_single", 32'(layer_done), 32'd0);
        check("done_idle_state", 32'(dbg_state), 32'd0);
      end
    end
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-ACCUM at elem_index 30
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      gen(4, w, x);
      w_data = w;
      x_data = x;
      w_valid = 1'b1;
      @(negedge clk);
    end
    w_valid = 1'b0;
    check("partial_elem", 32'(elem_index), 32'd30);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", 32'(dbg_state), 32'd0);
    check("post_reset_wready", 32'(w_ready), 32'd0);

    // Clean node after the aborted pass
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    node_ready = 1'b1;
    feed_node(3, 1'b0);
    collect(0);
    check("clean_next_col", 32'(column_number), 32'd1);
    check("exp_q_final", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
